// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared states and AXI constants for the read-channel arbiter.
package axi_rd_arb_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [2:0] SIZE_WORD = 3'd2;
endpackage

// File: rtl/axi_rd_arb_pick.sv
// axi_rd_arb_pick: winner select between fetch and load requests.
// With last_owner held at inst this reduces to fixed data-over-inst priority.
module axi_rd_arb_pick (
   input  logic inst_req,
   input  logic data_req,
   input  logic last_owner,
   output logic win_data
);
   assign win_data = data_req && !(inst_req && last_owner);
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between fetch and load requesters.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed data-first priority.
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int ID_W     = 4,
   parameter int INST_LEN = 0,
   parameter int DATA_LEN = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [1:0]        data_size,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] rdata_out,
   output logic              rd_err,
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready
);
   state_t state;
   logic   owner, grant, win_data, last_owner, beat, rid_unused;

   assign grant = resetn && state == IDLE && (inst_req || data_req);

`ifdef AXI_RD_ARB_RR_EN
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) last_owner <= ID_INST;
      else if (grant) last_owner <= win_data;
`else
   assign last_owner = ID_INST;
`endif

   axi_rd_arb_pick u_pick (
      .inst_req  (inst_req),
      .data_req  (data_req),
      .last_owner(last_owner),
      .win_data  (win_data)
   );

   assign inst_addr_ok = grant && !win_data;
   assign data_addr_ok = grant && win_data;
   // R side is a pure pass-through so beats reach the pipeline with no added latency
   assign beat         = state == DATA && rvalid;
   assign inst_data_ok = beat && owner == ID_INST;
   assign data_data_ok = beat && owner == ID_DATA;
   assign rdata_out    = beat ? rdata : '0;
   assign rd_err       = beat && rresp != RESP_OKAY;
   assign rready       = state == DATA;
   assign arvalid      = state == ADDR;
   assign arburst      = BURST_INCR;
   assign rid_unused   = ^rid;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state  <= IDLE;
         owner  <= ID_INST;
         araddr <= '0;
         arid   <= '0;
         arlen  <= '0;
         arsize <= '0;
      end else
         case (state)
            IDLE: if (grant) begin
               state  <= ADDR;
               owner  <= win_data;
               araddr <= win_data ? data_addr : inst_addr;
               arid   <= ID_W'(win_data ? ID_DATA : ID_INST);
               arlen  <= win_data ? 8'(DATA_LEN) : 8'(INST_LEN);
               arsize <= win_data ? {1'b0, data_size} : SIZE_WORD;
            end
            ADDR: if (arready) state <= DATA;
            DATA: if (rvalid && rlast) state <= IDLE;
            default: state <= IDLE;
         endcase
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Shares the core's single AXI read channel (AR/R) between the instruction-fetch requester and the data-load requester. Each requester uses an SRAM-like interface of req, addr_ok and data_ok. The block grants one requester at a time, issues exactly one AXI read transaction, and returns the beats to the owner. It sits between the fetch/memory pipeline stages and the top-level AXI master port. Pipeline stalls are derived from its addr_ok/data_ok handshakes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, AXI ID width
INST_LEN, 0, arlen (beats-1) for instruction reads
DATA_LEN, 0, arlen (beats-1) for data reads

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
inst_req  in  1  fetch request
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted (1-cycle pulse)
inst_data_ok  out  1  fetch beat valid (pulse per beat)
data_req  in  1  load request
data_addr  in  ADDR_W  load address
data_size  in  2  load size (0=byte, 1=half, 2=word)
data_addr_ok  out  1  load request accepted
data_data_ok  out  1  load beat valid
rdata_out  out  DATA_W  returned beat, shared by both requesters
rd_err  out  1  rresp!=OKAY on the current beat
arid  out  ID_W  0=inst, 1=data
araddr  out  ADDR_W  latched address
arlen  out  8  INST_LEN or DATA_LEN
arsize  out  3  inst=2, data=data_size
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  ID_W  response id (not checked)
rdata  in  DATA_W  response data
rresp  in  2  response status
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (resetn=0, async): state=IDLE. arvalid, rready, *_addr_ok, *_data_ok and rd_err=0. araddr/arid/arlen/arsize=0. Owner=none. Any in-flight AXI transaction is abandoned; the interconnect shares resetn.
- Three-state FSM: IDLE, ADDR, DATA.
- IDLE:
  - If any req is high, pick a winner: data before inst by default (see Optional Feature).
  - Assert winner's *_addr_ok combinationally in the same cycle.
  - Latch addr, id, len and size into AR registers. Next state = ADDR.
  - Loser sees addr_ok=0 and must hold its req.
- ADDR: arvalid=1 with stable payload until arready=1. On arvalid&&arready, next state = DATA; arvalid deasserts the next cycle.
- DATA:
  - rready=1.
  - Each rvalid beat: rdata_out=rdata, owner's *_data_ok=1, rd_err=(rresp!=0). All combinational from R inputs, zero added latency.
  - On rvalid&&rlast, next state = IDLE. A new request can be granted the following cycle; no IDLE bypass.
- Minimum latency: req@T0 -> addr_ok@T0 -> arvalid@T1 (arready@T1) -> rready@T2 -> data_ok in the same cycle as the first rvalid (≥T2).
- One outstanding transaction at most; rid is ignored.
- No req is accepted outside IDLE: *_addr_ok=0 in ADDR and DATA.
- rlast on an intermediate beat ends the transaction early; no error is flagged.
- Dropping req after addr_ok does not cancel the transaction; beats are still delivered.
- Non-owner *_data_ok is always 0.

Optional Feature:
Macro AXI_RD_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_owner register, reset to inst, records the owner. On a simultaneous request the non-last owner wins; a single request wins unconditionally.
- Undefined: fixed priority, data always beats inst. No last_owner register.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - State enum {IDLE, ADDR, DATA}.
  - ID_INST=0, ID_DATA=1.
  - BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_WORD=3'd2.
- One natural sub-module, axi_rd_arb_pick: combinational winner select from two reqs plus last_owner, covering both macro variants.

Test Plan:
- Inst only, inst_addr=0x1FC0_0000, arready and rvalid/rlast immediate -> addr_ok@T0; arvalid@T1 with arid=0, araddr=0x1FC0_0000, arsize=2; inst_data_ok@T2 with rdata_out=rdata.
- Both reqs in the same cycle, fixed priority -> data_addr_ok=1, inst_addr_ok=0, arid=1. Inst is granted the cycle after the data rlast.
- AXI_RD_ARB_RR_EN with both reqs held high for 4 transactions -> grants alternate data, inst, data, inst.
- arready held low 5 cycles -> arvalid stays 1 with araddr/arid/arsize stable; no addr_ok pulses meanwhile.
- INST_LEN=3, 4 beats with rvalid gaps and rresp=2 on beat 2 -> exactly 4 inst_data_ok pulses; rd_err=1 only on beat 2; IDLE after rlast.
- resetn low during DATA -> all outputs 0 immediately; after release, a new data req gets data_addr_ok in the first cycle.
